// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: fetch/decode/execute/memory/write-back
// sequencing with sticky HALT/TRAP states and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_write,
    output logic [2:0]       state,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    // state  | meaning
    // IDLE   | one cycle after reset release
    // FETCH  | instruction read, waits on mem_ready
    // DECODE | latch opcode, classify
    // EXEC   | branch resolves here, others move on
    // MEM    | load/store access, waits on mem_ready
    // WB     | register write-back and PC update
    // HALT   | sticky stop on SYSTEM opcode
    // TRAP   | sticky stop on illegal opcode
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     cur;
    logic [6:0] op_q;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= S_IDLE;
            op_q    <= 7'd0;
            retired <= '0;
        end else begin
            if (pc_write)
                retired <= retired + CNT_ONE;
            case (cur)
                S_IDLE:   cur <= S_FETCH;
                S_FETCH:  if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    if (opcode == OP_SYS)
                        cur <= S_HALT;
                    else if (!is_legal(opcode))
                        cur <= S_TRAP;
                    else
                        cur <= S_EXEC;
                end
                S_EXEC: begin
                    if (op_q == OP_BR)
                        cur <= S_FETCH;
                    else if (op_q == OP_LOAD || op_q == OP_STORE)
                        cur <= S_MEM;
                    else
                        cur <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready)
                        cur <= (op_q == OP_LOAD) ? S_WB : S_FETCH;
                end
                S_WB:     cur <= S_FETCH;
                S_HALT:   cur <= S_HALT;
                S_TRAP:   cur <= S_TRAP;
                default:  cur <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_write = 1'b0;
        halted    = 1'b0;
        trap      = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
            end
            S_EXEC: begin
                if (op_q == OP_BR) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_STORE);
                if (op_q == OP_STORE && mem_ready)
                    pc_write = 1'b1;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = (op_q == OP_JAL || op_q == OP_JALR);
            end
            S_HALT: halted = 1'b1;
            S_TRAP: begin
                halted = 1'b1;
                trap   = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// expected per-cycle trace from the instruction-class rules, then driven and compared.
module tb_multicycle_ctrl;
    localparam int CNT_W = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    // strobe vector order: {ir_write, pc_write, mem_req, mem_we, reg_write, halted, trap}
    localparam logic [6:0] IRW = 7'b1000000;
    localparam logic [6:0] PCW = 7'b0100000;
    localparam logic [6:0] MRQ = 7'b0010000;
    localparam logic [6:0] MWE = 7'b0001000;
    localparam logic [6:0] RGW = 7'b0000100;
    localparam logic [6:0] HLT = 7'b0000010;
    localparam logic [6:0] TRP = 7'b0000001;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                           ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6, ST_TRAP = 3'd7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             branch_taken;
    logic             ir_write, pc_write, pc_src, mem_req, mem_we, reg_write;
    logic [2:0]       state;
    logic             halted, trap;
    logic [CNT_W-1:0] retired;

    int checks = 0;
    int errors = 0;
    int model_ret = 0;

    logic [6:0] legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
                                  OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write),
        .state(state), .halted(halted), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [6:0] op);
        is_legal = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == op) is_legal = 1'b1;
    endfunction

    function automatic logic [6:0] rnd_op();
        rnd_op = 7'($urandom_range(0, 127));
    endfunction

    function automatic logic rnd_bit();
        rnd_bit = 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rnd_illegal();
        logic [6:0] r;
        r = rnd_op();
        while (is_legal(r) || r == OP_SYS) r = rnd_op();
        rnd_illegal = r;
    endfunction

    // Called just after a rising edge; drives one cycle and checks it at the falling edge.
    task automatic step(input logic rdy, input logic [6:0] op, input logic bt,
                        input logic [2:0] exp_st, input logic [6:0] exp_sb, input logic exp_src);
        mem_ready    = rdy;
        opcode       = op;
        branch_taken = bt;
        @(negedge clk);
        check_eq("state", 32'(state), 32'(exp_st));
        check_eq("strobes", 32'({ir_write, pc_write, mem_req, mem_we, reg_write, halted, trap}),
                 32'(exp_sb));
        check_eq("retired", 32'(retired), 32'(model_ret));
        if ((exp_sb & PCW) != 7'd0) begin
            check_eq("pc_src", 32'(pc_src), 32'(exp_src));
            model_ret = (model_ret + 1) % (1 << CNT_W);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_ret = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            mem_ready = rnd_bit();
            opcode    = rnd_op();
            @(negedge clk);
            check_eq("rst_state", 32'(state), 32'(ST_IDLE));
            check_eq("rst_strobes", 32'({ir_write, pc_write, pc_src, mem_req, mem_we,
                                         reg_write, halted, trap}), 32'd0);
            check_eq("rst_retired", 32'(retired), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(rnd_bit(), rnd_op(), rnd_bit(), ST_IDLE, 7'd0, 1'b0);
    endtask

    task automatic fetch_decode(input logic [6:0] op, input int fw);
        for (int i = 0; i < fw; i++) step(1'b0, rnd_op(), rnd_bit(), ST_FETCH, MRQ, 1'b0);
        step(1'b1, rnd_op(), rnd_bit(), ST_FETCH, MRQ | IRW, 1'b0);
        step(rnd_bit(), op, rnd_bit(), ST_DECODE, 7'd0, 1'b0);
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic bt);
        logic is_mem;
        fetch_decode(op, fw);
        if (op == OP_SYS || !is_legal(op)) begin
            for (int i = 0; i < 20; i++)
                step(rnd_bit(), rnd_op(), rnd_bit(), (op == OP_SYS) ? ST_HALT : ST_TRAP,
                     (op == OP_SYS) ? HLT : (HLT | TRP), 1'b0);
            return;
        end
        if (op == OP_BR) begin
            step(rnd_bit(), rnd_op(), bt, ST_EXEC, PCW, bt);
            return;
        end
        step(rnd_bit(), rnd_op(), rnd_bit(), ST_EXEC, 7'd0, 1'b0);
        is_mem = (op == OP_LOAD || op == OP_STORE);
        if (is_mem) begin
            for (int i = 0; i < mw; i++)
                step(1'b0, rnd_op(), rnd_bit(), ST_MEM, (op == OP_STORE) ? (MRQ | MWE) : MRQ, 1'b0);
            step(1'b1, rnd_op(), rnd_bit(), ST_MEM,
                 (op == OP_STORE) ? (MRQ | MWE | PCW) : MRQ, 1'b0);
            if (op == OP_STORE) return;
        end
        step(rnd_bit(), rnd_op(), rnd_bit(), ST_WB, RGW | PCW, (op == OP_JAL || op == OP_JALR));
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        opcode = 7'd0;
        branch_taken = 1'b0;

        // R-type with zero wait: retire lands 5 edges after release
        do_reset();
        run_instr(OP_R, 0, 0, 1'b0);
        check_eq("rtype_retired", 32'(retired), 32'd1);

        run_instr(OP_LOAD, 3, 3, 1'b0);
        run_instr(OP_STORE, 1, 2, 1'b0);
        run_instr(OP_BR, 0, 0, 1'b1);
        run_instr(OP_BR, 2, 0, 1'b0);
        run_instr(OP_JAL, 0, 0, 1'b0);
        run_instr(OP_JALR, 1, 0, 1'b0);

        run_instr(7'b1111111, 0, 0, 1'b0);
        do_reset();
        run_instr(OP_SYS, 1, 0, 1'b0);

        // counter wrap at CNT_W=4
        do_reset();
        for (int i = 0; i < 15; i++) run_instr(OP_I, 0, 0, 1'b0);
        check_eq("ret_allones", 32'(retired), 32'hF);
        run_instr(OP_LUI, 0, 0, 1'b0);
        check_eq("ret_wrap", 32'(retired), 32'd0);

        // reset while a MEM access is pending must drop mem_req before any edge
        run_instr(OP_AUIPC, 0, 0, 1'b0);
        fetch_decode(OP_LOAD, 0);
        step(1'b0, rnd_op(), 1'b0, ST_EXEC, 7'd0, 1'b0);
        step(1'b0, rnd_op(), 1'b0, ST_MEM, MRQ, 1'b0);
        mem_ready = 1'b0;
        #1;
        check_eq("mem_pending", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_state", 32'(state), 32'(ST_IDLE));
        check_eq("async_mem_req", 32'(mem_req), 32'd0);
        check_eq("async_retired", 32'(retired), 32'd0);
        do_reset();

        // reset while FETCH is waiting
        step(1'b0, rnd_op(), 1'b0, ST_FETCH, MRQ, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_fetch_state", 32'(state), 32'(ST_IDLE));
        check_eq("async_fetch_req", 32'(mem_req), 32'd0);

        for (int run = 0; run < 6; run++) begin
            int n;
            int term;
            do_reset();
            n = $urandom_range(10, 25);
            for (int k = 0; k < n; k++)
                run_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 3),
                          $urandom_range(0, 3), rnd_bit());
            term = $urandom_range(0, 2);
            if (term == 1) run_instr(OP_SYS, $urandom_range(0, 2), 0, 1'b0);
            else if (term == 2) run_instr(rnd_illegal(), $urandom_range(0, 2), 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
